// File: rtl/bec_pkg.sv
// bec_pkg
//   Shared constants for the BEC operand loader: field and chunk widths,
//   FSM state encodings, LA command codes and the slot-to-operand mapping.
//   No ports.
package bec_pkg;

  localparam int FIELD_W   = 163;
  localparam int CHUNK_W   = 82;
  localparam int HI_W      = FIELD_W - CHUNK_W;   // 81 bits carried by even slots
  localparam int NUM_OPS   = 7;
  localparam int NUM_SLOTS = 2 * NUM_OPS;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b11;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [15:0] CMD_OPEN    = 16'hAB30;
  localparam logic [15:0] CMD_LAUNCH  = 16'hAB41;
  localparam logic [15:0] CMD_RELEASE = 16'hAB10;

  // Operand index = slot >> 1
  localparam int OP_W1     = 0;
  localparam int OP_Z1     = 1;
  localparam int OP_W2     = 2;
  localparam int OP_Z2     = 3;
  localparam int OP_INV_W0 = 4;
  localparam int OP_D      = 5;
  localparam int OP_KEY    = 6;

  function automatic logic is_known_cmd(input logic [15:0] code);
    return (code == CMD_OPEN) || (code == CMD_LAUNCH) || (code == CMD_RELEASE);
  endfunction

endpackage

// File: rtl/bec_la_event_detect.sv
// bec_la_event_detect
//   Turns level-style LA fields into single-cycle events.
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   i_toggle     LA data toggle bit
//   i_cmd        LA command field
//   o_data_evt   toggle differs from stored value
//   o_cmd_evt    command field changed to a known code
//   o_cmd_code   current command field
import bec_pkg::*;

module bec_la_event_detect (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_toggle,
  input  logic [15:0] i_cmd,
  output logic        o_data_evt,
  output logic        o_cmd_evt,
  output logic [15:0] o_cmd_code
);

  logic        r_toggle;
  logic [15:0] r_cmd;

  // Storing the toggle every cycle is equivalent to storing it on each
  // data event: when there is no event the value is unchanged anyway.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_toggle <= 1'b0;
      r_cmd    <= '0;
    end else begin
      r_toggle <= i_toggle;
      r_cmd    <= i_cmd;
    end
  end

  assign o_data_evt = (i_toggle != r_toggle);
  assign o_cmd_evt  = (i_cmd != r_cmd) && is_known_cmd(i_cmd);
  assign o_cmd_code = i_cmd;

endmodule

// File: rtl/bec_operand_loader.sv
// bec_operand_loader
//   Assembles the seven 163-bit BEC operands from 82-bit LA chunks, tracks
//   which halves are loaded and launches the point-mult core. Owns the key
//   register and shifts it on the core's next_key request.
//   wb_clk_i        clock
//   wb_rst_i        synchronous active-high reset
//   la_word         [127] data toggle, [91:88] slot, [81:0] payload, [31:16] command
//   core_next_key   shift key right by one (RUN only)
//   core_done       core finished
//   w1..d           operand registers
//   key_bit         key[0]
//   core_start      one-cycle launch pulse (first RUN cycle)
//   core_enable     high throughout RUN
//   operands_valid  all slots loaded
//   status          {state, err_slot, err_incomplete, err_busy, mask}
//
//   state | meaning
//   IDLE  | operands cleared, waiting for OPEN; data ignored
//   LOAD  | data events write slots; LAUNCH checks completeness
//   RUN   | core enabled; key shifts on request; data flagged busy
//   DONE  | core finished; operands held until RELEASE
import bec_pkg::*;

module bec_operand_loader (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [127:0]       la_word,
  input  logic               core_next_key,
  input  logic               core_done,
  output logic [FIELD_W-1:0] w1,
  output logic [FIELD_W-1:0] z1,
  output logic [FIELD_W-1:0] w2,
  output logic [FIELD_W-1:0] z2,
  output logic [FIELD_W-1:0] inv_w0,
  output logic [FIELD_W-1:0] d,
  output logic               key_bit,
  output logic               core_start,
  output logic               core_enable,
  output logic               operands_valid,
  output logic [18:0]        status
);

  logic [1:0]           r_state;
  logic [FIELD_W-1:0]   r_op [NUM_OPS];
  logic [NUM_SLOTS-1:0] r_mask;
  logic                 r_err_slot;
  logic                 r_err_incomplete;
  logic                 r_err_busy;
  logic                 r_start;

  logic                 w_data_evt;
  logic                 w_cmd_evt;
  logic [15:0]          w_cmd_code;
  logic [3:0]           w_slot;
  logic [CHUNK_W-1:0]   w_payload;
  logic [2:0]           w_op_idx;
  logic                 w_slot_ok;
  logic                 w_wr_en;
  logic [NUM_SLOTS-1:0] w_slot_bit;
  logic [NUM_SLOTS-1:0] w_mask_next;
  logic                 w_open;
  logic                 w_launch;
  logic                 w_release;
  logic                 w_unused_la;

  bec_la_event_detect u_evt (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_toggle   (la_word[127]),
    .i_cmd      (la_word[31:16]),
    .o_data_evt (w_data_evt),
    .o_cmd_evt  (w_cmd_evt),
    .o_cmd_code (w_cmd_code)
  );

  assign w_slot      = la_word[91:88];
  assign w_payload   = la_word[CHUNK_W-1:0];
  assign w_op_idx    = w_slot[3:1];
  assign w_slot_ok   = (w_slot < 4'(NUM_SLOTS));
  assign w_wr_en     = (r_state == ST_LOAD) && w_data_evt && w_slot_ok;
  assign w_slot_bit  = w_wr_en ? (NUM_SLOTS'(1) << w_slot) : '0;
  // LAUNCH sees a slot written in the same cycle
  assign w_mask_next = r_mask | w_slot_bit;
  assign w_unused_la = ^{la_word[126:92], la_word[87:82]};

  assign w_open    = w_cmd_evt && (w_cmd_code == CMD_OPEN);
  assign w_launch  = w_cmd_evt && (w_cmd_code == CMD_LAUNCH);
  assign w_release = w_cmd_evt && (w_cmd_code == CMD_RELEASE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state          <= ST_IDLE;
      r_mask           <= '0;
      r_err_slot       <= 1'b0;
      r_err_incomplete <= 1'b0;
      r_err_busy       <= 1'b0;
      r_start          <= 1'b0;
      for (int i = 0; i < NUM_OPS; i++) r_op[i] <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_open) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (w_release) begin
            r_state          <= ST_IDLE;
            r_mask           <= '0;
            r_err_slot       <= 1'b0;
            r_err_incomplete <= 1'b0;
            r_err_busy       <= 1'b0;
            for (int i = 0; i < NUM_OPS; i++) r_op[i] <= '0;
          end else begin
            if (w_wr_en) begin
              if (w_slot[0])
                r_op[w_op_idx][CHUNK_W-1:0] <= w_payload;
              else
                r_op[w_op_idx][FIELD_W-1:CHUNK_W] <= w_payload[HI_W-1:0];
              r_mask <= w_mask_next;
            end else if (w_data_evt) begin
              r_err_slot <= 1'b1;
            end
            if (w_launch) begin
              if (&w_mask_next) begin
                r_state <= ST_RUN;
                r_start <= 1'b1;
              end else begin
                r_err_incomplete <= 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          if (w_data_evt) r_err_busy <= 1'b1;
          if (core_next_key)
            r_op[OP_KEY] <= {1'b0, r_op[OP_KEY][FIELD_W-1:1]};
          if (core_done) r_state <= ST_DONE;
        end
        default: begin
          if (w_release) begin
            r_state          <= ST_IDLE;
            r_mask           <= '0;
            r_err_slot       <= 1'b0;
            r_err_incomplete <= 1'b0;
            r_err_busy       <= 1'b0;
            for (int i = 0; i < NUM_OPS; i++) r_op[i] <= '0;
          end
        end
      endcase
    end
  end

  assign w1             = r_op[OP_W1];
  assign z1             = r_op[OP_Z1];
  assign w2             = r_op[OP_W2];
  assign z2             = r_op[OP_Z2];
  assign inv_w0         = r_op[OP_INV_W0];
  assign d              = r_op[OP_D];
  assign key_bit        = r_op[OP_KEY][0];
  assign core_start     = r_start;
  assign core_enable    = (r_state == ST_RUN);
  assign operands_valid = &r_mask;
  assign status         = {r_state, r_err_slot, r_err_incomplete, r_err_busy, r_mask};

endmodule
